// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: FSM states, register
// addresses on the SPART ioaddr bus and status-byte bit positions.
package spart_pkg;

    // One bus cycle per state; iocs is asserted in every state.
    typedef enum logic [2:0] {
        StInitLo,
        StInitHi,
        StPoll,
        StRxRead,
        StTxWrite,
        StCfgLo,
        StCfgHi
    } spart_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    // Status byte bit indices: receive data available, transmit buffer ready.
    localparam int unsigned STAT_RDA = 0;
    localparam int unsigned STAT_TBR = 1;

endpackage

// File: rtl/spart_ctrl.sv
// SPART bus master: programs the baud divisor after reset, then polls the
// status register and moves bytes between the SPART and the rx/tx
// handshakes, with on-the-fly divisor rewrites via cfg_valid.
module spart_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV = 16'd325
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_div,
    output logic        cfg_done
);

    spart_state_e state_q, state_d;
    logic [15:0]  div_q;
    logic [7:0]   rx_data_q;
    logic         rx_valid_q;
    logic [7:0]   bus_out;
    logic         rx_capture;
    logic         cfg_latch;

    // State register; reset parks the FSM at the start of the divisor sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInitLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Divisor latch: reset restores the build-time divisor, dropping any cfg request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= BAUD_DIV;
        end else if (cfg_latch) begin
            div_q <= cfg_div;
        end
    end

    // Receive holding register; a byte captured this cycle cannot be consumed
    // until rx_valid is visible, so capture wins over rx_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else if (rx_capture) begin
            rx_data_q  <= databus;
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Next-state and per-cycle bus outputs; reset gates every strobe off at once.
    always_comb begin
        state_d    = state_q;
        iocs       = 1'b1;
        iorw       = 1'b1;
        ioaddr     = ADDR_STATUS;
        bus_out    = 8'h00;
        tx_ready   = 1'b0;
        cfg_done   = 1'b0;
        rx_capture = 1'b0;
        cfg_latch  = 1'b0;

        unique case (state_q)
            StInitLo: begin
                iorw    = 1'b0;
                ioaddr  = ADDR_DIV_LO;
                bus_out = div_q[7:0];
                state_d = StInitHi;
            end
            StInitHi: begin
                iorw    = 1'b0;
                ioaddr  = ADDR_DIV_HI;
                bus_out = div_q[15:8];
                state_d = StPoll;
            end
            StPoll: begin
                // Status is read live off the bus and consumed at this edge only.
                if (cfg_valid) begin
                    cfg_latch = 1'b1;
                    state_d   = StCfgLo;
                end else if (databus[STAT_RDA] && !rx_valid_q) begin
                    state_d = StRxRead;
                end else if (databus[STAT_TBR] && tx_valid) begin
                    state_d = StTxWrite;
                end
            end
            StRxRead: begin
                ioaddr     = ADDR_DATA;
                rx_capture = 1'b1;
                state_d    = StPoll;
            end
            StTxWrite: begin
                iorw     = 1'b0;
                ioaddr   = ADDR_DATA;
                bus_out  = tx_data;
                tx_ready = 1'b1;
                state_d  = StPoll;
            end
            StCfgLo: begin
                iorw    = 1'b0;
                ioaddr  = ADDR_DIV_LO;
                bus_out = div_q[7:0];
                state_d = StCfgHi;
            end
            StCfgHi: begin
                iorw     = 1'b0;
                ioaddr   = ADDR_DIV_HI;
                bus_out  = div_q[15:8];
                cfg_done = 1'b1;
                state_d  = StPoll;
            end
            default: state_d = StInitLo;
        endcase

        if (!rst_n) begin
            iocs     = 1'b0;
            iorw     = 1'b1;
            tx_ready = 1'b0;
            cfg_done = 1'b0;
        end
    end

    // Bus is driven only on writes; iorw is forced high during reset.
    assign databus  = iorw ? 8'bzzzz_zzzz : bus_out;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spart_ctrl.sv
// Directed bench for spart_ctrl: a behavioural SPART answers status and data
// reads; each check compares a DUT output with a hand-computed value.
module tb_spart_ctrl;
    import spart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic        cfg_done;

    // Behavioural SPART: answers reads; parks 8'h5A on the bus during reset so a
    // DUT that wrongly drives there corrupts the observed value.
    logic [7:0] status;
    logic [7:0] rx_byte;
    logic       tb_en;
    logic [7:0] tb_val;
    assign tb_en   = !rst_n || (iocs && iorw);
    assign tb_val  = !rst_n ? 8'h5A : ((ioaddr == ADDR_STATUS) ? status : rx_byte);
    assign databus = tb_en ? tb_val : 8'bzzzz_zzzz;

    int checks = 0;
    int errors = 0;

    spart_ctrl #(.BAUD_DIV(16'd325)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_done  (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 16'h0000;
        status    = 8'h00;
        rx_byte   = 8'h00;

        // Reset state
        step();
        step();
        check_eq("rst_iocs", iocs, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_tx_ready", tx_ready, 0);
        check_eq("rst_cfg_done", cfg_done, 0);
        check_eq("rst_bus_z", databus, 8'h5A);

        // Divisor init sequence: 325 = 16'h0145
        rst_n = 1'b1;
        #1;
        check_eq("init_lo_iocs", iocs, 1);
        check_eq("init_lo_iorw", iorw, 0);
        check_eq("init_lo_addr", ioaddr, 2'b10);
        check_eq("init_lo_bus", databus, 8'h45);
        step();
        check_eq("init_hi_addr", ioaddr, 2'b11);
        check_eq("init_hi_bus", databus, 8'h01);
        step();
        check_eq("poll_iorw", iorw, 1);
        check_eq("poll_addr", ioaddr, 2'b01);
        step();
        check_eq("poll_idle_addr", ioaddr, 2'b01);

        // Receive A5, then hold it with rx_ready low while rda stays set
        status  = 8'h01;
        rx_byte = 8'hA5;
        step();
        check_eq("rx_read_addr", ioaddr, 2'b00);
        check_eq("rx_read_iorw", iorw, 1);
        check_eq("rx_read_valid", rx_valid, 0);
        step();
        check_eq("rx_valid_set", rx_valid, 1);
        check_eq("rx_data_a5", rx_data, 8'hA5);
        check_eq("rx_hold_addr0", ioaddr, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rx_hold_poll", ioaddr, 2'b01);
            check_eq("rx_hold_valid", rx_valid, 1);
        end
        rx_ready = 1'b1;
        status   = 8'h00;
        step();
        rx_ready = 1'b0;
        check_eq("rx_consumed", rx_valid, 0);
        check_eq("rx_consumed_addr", ioaddr, 2'b01);

        // Transmit 3C: no write while tbr is clear
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        check_eq("tx_wait_ready", tx_ready, 0);
        check_eq("tx_wait_addr", ioaddr, 2'b01);
        status = 8'h02;
        step();
        check_eq("tx_iorw", iorw, 0);
        check_eq("tx_addr", ioaddr, 2'b00);
        check_eq("tx_bus", databus, 8'h3C);
        check_eq("tx_ready_pulse", tx_ready, 1);
        tx_valid = 1'b0;
        step();
        check_eq("tx_ready_clear", tx_ready, 0);
        check_eq("tx_back_poll", ioaddr, 2'b01);

        // rda and tbr both set: RX_READ, POLL, TX_WRITE
        status   = 8'h03;
        rx_byte  = 8'h5E;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        step();
        check_eq("both_rx_addr", ioaddr, 2'b00);
        check_eq("both_rx_iorw", iorw, 1);
        check_eq("both_rx_txr", tx_ready, 0);
        step();
        check_eq("both_poll_addr", ioaddr, 2'b01);
        check_eq("both_rx_data", rx_data, 8'h5E);
        step();
        check_eq("both_tx_addr", ioaddr, 2'b00);
        check_eq("both_tx_bus", databus, 8'h77);
        check_eq("both_tx_ready", tx_ready, 1);
        tx_valid = 1'b0;
        status   = 8'h00;
        step();
        check_eq("both_end_poll", ioaddr, 2'b01);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check_eq("both_rx_drained", rx_valid, 0);

        // Divisor rewrite beats a simultaneous rda; cfg_div latched at accept
        status    = 8'h01;
        rx_byte   = 8'h99;
        cfg_valid = 1'b1;
        cfg_div   = 16'h0A2B;
        step();
        cfg_valid = 1'b0;
        cfg_div   = 16'hFFFF;
        check_eq("cfg_lo_addr", ioaddr, 2'b10);
        check_eq("cfg_lo_bus", databus, 8'h2B);
        check_eq("cfg_lo_done", cfg_done, 0);
        step();
        check_eq("cfg_hi_addr", ioaddr, 2'b11);
        check_eq("cfg_hi_bus", databus, 8'h0A);
        check_eq("cfg_hi_done", cfg_done, 1);
        step();
        check_eq("cfg_poll_addr", ioaddr, 2'b01);
        check_eq("cfg_done_clear", cfg_done, 0);
        step();
        check_eq("cfg_then_rx", ioaddr, 2'b00);
        status = 8'h00;
        step();
        check_eq("held_rx_valid", rx_valid, 1);
        check_eq("held_rx_data", rx_data, 8'h99);

        // Reset during TX_WRITE aborts at once and discards the held rx byte
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        status   = 8'h02;
        step();
        check_eq("rst_tx_ready_pre", tx_ready, 1);
        check_eq("rst_tx_bus_pre", databus, 8'hC3);
        rst_n = 1'b0;
        #1;
        check_eq("abort_iocs", iocs, 0);
        check_eq("abort_tx_ready", tx_ready, 0);
        check_eq("abort_bus_z", databus, 8'h5A);
        check_eq("abort_rx_valid", rx_valid, 0);
        check_eq("abort_rx_data", rx_data, 0);
        tx_valid = 1'b0;
        status   = 8'h00;
        step();
        rst_n = 1'b1;
        #1;
        check_eq("reinit_lo_addr", ioaddr, 2'b10);
        check_eq("reinit_lo_bus", databus, 8'h45);
        check_eq("reinit_iocs", iocs, 1);
        step();
        check_eq("reinit_hi_addr", ioaddr, 2'b11);
        check_eq("reinit_hi_bus", databus, 8'h01);
        step();
        check_eq("reinit_poll", ioaddr, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
